// File: rtl/row_scorer_if.sv
// row_scorer_if: cursor-write / submit inputs and scored-row outputs of row_scorer.
// master drives we/columnIn/value/submitted/targetFlat; slave returns the row state.
interface row_scorer_if;
    logic        we;
    logic [2:0]  columnIn;
    logic [6:0]  value;
    logic        submitted;
    logic [24:0] targetFlat;
    logic [34:0] rowValuesFlat;
    logic [34:0] scoredFlat;
    logic        scoreValid;
    logic        rejected;
    logic        busy;
    logic [2:0]  rowIndex;
    logic        doneGame;
    logic        won;

    modport master (
        output we, columnIn, value, submitted, targetFlat,
        input  rowValuesFlat, scoredFlat, scoreValid, rejected,
        input  busy, rowIndex, doneGame, won
    );

    modport slave (
        input  we, columnIn, value, submitted, targetFlat,
        output rowValuesFlat, scoredFlat, scoreValid, rejected,
        output busy, rowIndex, doneGame, won
    );
endinterface

// File: rtl/row_scorer.sv
// row_scorer: live guess-row buffer plus Wordle scorer with duplicate-letter rules.
// Ports: clk, clr_n (async active-low), bus (row_scorer_if.slave: writes, submit, scored row, status).
module row_scorer (
    input  logic         clk,
    input  logic         clr_n,
    row_scorer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, GREEN, YEL0, YEL1, YEL2, YEL3, YEL4, DONE
    } state_t;

    localparam logic [4:0] BLANK = 5'd26;

    state_t      r_state;
    logic [4:0]  r_buf   [5];
    logic [4:0]  r_snap  [5];
    logic [1:0]  r_color [5];
    logic [4:0]  r_used;
    logic [34:0] r_scored;
    logic        r_scoreValid;
    logic        r_rejected;
    logic        r_busy;
    logic [2:0]  r_rowIndex;
    logic        r_done;
    logic        r_won;

    logic [4:0]  w_tgt  [5];
    logic [4:0]  w_snap [5];
    logic        w_blank;
    logic        w_wr_ok;
    logic [2:0]  w_yi;
    logic        w_found;
    logic [2:0]  w_j;
    logic        w_allgreen;
    logic [34:0] w_scored;
    logic        w_unused;

    assign w_unused = &{1'b0, bus.value[6:5]};
    assign w_wr_ok  = bus.we && (bus.columnIn <= 3'd4);

    // Snapshot always merges the current cursor value into its column.
    always_comb begin
        w_blank = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w_tgt[k]  = bus.targetFlat[5*k +: 5];
            w_snap[k] = (bus.columnIn == 3'(k)) ? bus.value[4:0] : r_buf[k];
            if (w_snap[k] == BLANK) w_blank = 1'b1;
        end
    end

    // Yellow pass: descending scan so the lowest free matching slot wins.
    always_comb begin
        w_yi    = 3'(r_state) - 3'd2;
        if (w_yi > 3'd4) w_yi = 3'd0;
        w_found = 1'b0;
        w_j     = 3'd0;
        for (int j = 4; j >= 0; j--) begin
            if (!r_used[j] && w_tgt[j] == r_snap[w_yi]) begin
                w_found = 1'b1;
                w_j     = 3'(j);
            end
        end
    end

    always_comb begin
        w_allgreen = 1'b1;
        w_scored   = '0;
        for (int k = 0; k < 5; k++) begin
            if (r_color[k] != 2'd2) w_allgreen = 1'b0;
            w_scored[7*k +: 7] = {r_color[k], r_snap[k]};
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= IDLE;
            r_used       <= '0;
            r_scored     <= {5{2'b00, BLANK}};
            r_scoreValid <= 1'b0;
            r_rejected   <= 1'b0;
            r_busy       <= 1'b0;
            r_rowIndex   <= 3'd0;
            r_done       <= 1'b0;
            r_won        <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                r_buf[k]   <= BLANK;
                r_snap[k]  <= BLANK;
                r_color[k] <= 2'd0;
            end
        end else begin
            r_scoreValid <= 1'b0;
            r_rejected   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.submitted && !r_done && !w_blank) begin
                        // Accepted submit: clear beats a same-cycle write.
                        for (int k = 0; k < 5; k++) begin
                            r_snap[k] <= w_snap[k];
                            r_buf[k]  <= BLANK;
                        end
                        r_busy  <= 1'b1;
                        r_state <= GREEN;
                    end else begin
                        if (bus.submitted && !r_done) r_rejected <= 1'b1;
                        for (int k = 0; k < 5; k++) begin
                            if (w_wr_ok && bus.columnIn == 3'(k))
                                r_buf[k] <= bus.value[4:0];
                        end
                    end
                end
                GREEN: begin
                    for (int k = 0; k < 5; k++) begin
                        if (r_snap[k] == w_tgt[k]) begin
                            r_color[k] <= 2'd2;
                            r_used[k]  <= 1'b1;
                        end else begin
                            r_color[k] <= 2'd0;
                            r_used[k]  <= 1'b0;
                        end
                    end
                    r_state <= YEL0;
                end
                YEL0, YEL1, YEL2, YEL3, YEL4: begin
                    if (r_color[w_yi] != 2'd2 && w_found) begin
                        r_color[w_yi] <= 2'd1;
                        r_used[w_j]   <= 1'b1;
                    end
                    r_state <= state_t'(3'(r_state) + 3'd1);
                end
                DONE: begin
                    r_scored     <= w_scored;
                    r_scoreValid <= 1'b1;
                    r_rowIndex   <= r_rowIndex + 3'd1;
                    r_busy       <= 1'b0;
                    if (w_allgreen) begin
                        r_won  <= 1'b1;
                        r_done <= 1'b1;
                    end else if (r_rowIndex == 3'd5) begin
                        r_done <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rowValuesFlat = '0;
        for (int k = 0; k < 5; k++)
            bus.rowValuesFlat[7*k +: 7] = {2'b00, r_buf[k]};
    end

    assign bus.scoredFlat = r_scored;
    assign bus.scoreValid = r_scoreValid;
    assign bus.rejected   = r_rejected;
    assign bus.busy       = r_busy;
    assign bus.rowIndex   = r_rowIndex;
    assign bus.doneGame   = r_done;
    assign bus.won        = r_won;
endmodule

// File: tb/tb_row_scorer.sv
// tb_row_scorer: directed and random Wordle rows against a letter-count reference model.
// Drives row_scorer through row_scorer_if; reports one summary line.
module tb_row_scorer;
    logic clk = 1'b0;
    logic clr_n = 1'b0;

    row_scorer_if bus ();

    row_scorer dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [34:0] BLANKROW = {5{7'd26}};

    int checks = 0;
    int errors = 0;
    int exp_row = 0;
    bit exp_done = 0;
    bit exp_won = 0;

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: greens first, then yellows from a per-letter budget of unmatched target letters.
    function automatic logic [9:0] wordle(input logic [24:0] g, input logic [24:0] t);
        int cnt [32];
        logic [9:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        for (int k = 0; k < 5; k++) begin
            if (g[5*k +: 5] == t[5*k +: 5]) c[2*k +: 2] = 2'd2;
            else cnt[t[5*k +: 5]]++;
        end
        for (int k = 0; k < 5; k++) begin
            if (c[2*k +: 2] != 2'd2 && cnt[g[5*k +: 5]] > 0) begin
                c[2*k +: 2] = 2'd1;
                cnt[g[5*k +: 5]]--;
            end
        end
        return c;
    endfunction

    function automatic logic [34:0] flat_of(input logic [24:0] g, input logic [9:0] c);
        logic [34:0] f;
        for (int k = 0; k < 5; k++) f[7*k +: 7] = {c[2*k +: 2], g[5*k +: 5]};
        return f;
    endfunction

    function automatic logic [24:0] rand_word();
        logic [24:0] w;
        for (int k = 0; k < 5; k++) w[5*k +: 5] = 5'($urandom_range(0, 25));
        return w;
    endfunction

    // Random guess biased toward target letters to provoke duplicate handling.
    function automatic logic [24:0] rand_guess(input logic [24:0] t);
        logic [24:0] w;
        for (int k = 0; k < 5; k++) begin
            if ($urandom_range(0, 1) == 1) w[5*k +: 5] = t[5*$urandom_range(0, 4) +: 5];
            else w[5*k +: 5] = 5'($urandom_range(0, 25));
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_col(input int c, input logic [4:0] l);
        bus.we = 1'b1;
        bus.columnIn = 3'(c);
        bus.value = {2'($urandom), l};
        tick();
        bus.we = 1'b0;
    endtask

    // Writes columns 0..3, then writes column 4 in the same cycle as the submit.
    task automatic submit_row(input logic [24:0] g);
        for (int k = 0; k < 4; k++) write_col(k, g[5*k +: 5]);
        bus.we = 1'b1;
        bus.columnIn = 3'd4;
        bus.value = {2'($urandom), g[20 +: 5]};
        bus.submitted = 1'b1;
        tick();
        bus.we = 1'b0;
        bus.submitted = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_row"}, bus.rowValuesFlat, BLANKROW);
        chk({tag, "_scored"}, bus.scoredFlat, BLANKROW);
        chk({tag, "_status"},
            {bus.rowIndex, bus.doneGame, bus.won, bus.busy, bus.scoreValid, bus.rejected}, '0);
    endtask

    task automatic reset_dut(input string tag);
        #2 clr_n = 1'b0;
        #1 check_reset(tag);
        tick();
        clr_n = 1'b1;
        exp_row = 0;
        exp_done = 0;
        exp_won = 0;
        tick();
    endtask

    task automatic scored_row(input logic [24:0] g, input logic [9:0] expc, input string tag);
        int lat;
        lat = 0;
        submit_row(g);
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_clear"}, bus.rowValuesFlat, BLANKROW);
        chk({tag, "_norej"}, bus.rejected, 0);
        // Keep poking we/submitted while busy; both must be ignored.
        for (int n = 1; n <= 12; n++) begin
            bus.we = 1'b1;
            bus.columnIn = 3'($urandom_range(0, 4));
            bus.value = 7'($urandom_range(0, 25));
            bus.submitted = 1'b1;
            tick();
            if (bus.scoreValid) begin
                lat = n;
                break;
            end
        end
        bus.we = 1'b0;
        bus.submitted = 1'b0;
        exp_row++;
        if (expc == 10'b10_10_10_10_10) begin
            exp_won = 1;
            exp_done = 1;
        end else if (exp_row == 6) begin
            exp_done = 1;
        end
        chk({tag, "_latency"}, 35'(lat), 35'd7);
        chk({tag, "_scored"}, bus.scoredFlat, flat_of(g, expc));
        chk({tag, "_rowidx"}, bus.rowIndex, 35'(exp_row));
        chk({tag, "_flags"}, {bus.doneGame, bus.won, bus.busy}, {exp_done, exp_won, 1'b0});
        chk({tag, "_busyign"}, bus.rowValuesFlat, BLANKROW);
        tick();
        chk({tag, "_svpulse"}, bus.scoreValid, 0);
    endtask

    task automatic ignored_submit(input logic [24:0] g, input string tag);
        int sv;
        int rj;
        sv = 0;
        rj = 0;
        submit_row(g);
        for (int n = 0; n < 10; n++) begin
            if (bus.scoreValid) sv++;
            if (bus.rejected) rj++;
            if (bus.busy) sv++;
            tick();
        end
        chk({tag, "_nosv"}, 35'(sv), 0);
        chk({tag, "_norej"}, 35'(rj), 0);
        chk({tag, "_kept"}, bus.rowValuesFlat, flat_of(g, 10'd0));
        chk({tag, "_row"}, bus.rowIndex, 35'(exp_row));
    endtask

    initial begin
        logic [24:0] tgt;
        logic [24:0] g;
        logic [34:0] expf;
        int cnt;
        bus.we = 1'b0;
        bus.columnIn = 3'd0;
        bus.value = 7'd0;
        bus.submitted = 1'b0;
        bus.targetFlat = '0;
        clr_n = 1'b0;
        tick();
        tick();
        check_reset("reset");
        clr_n = 1'b1;
        tick();

        // APPLE vs PAPER
        bus.targetFlat = {5'd4, 5'd11, 5'd15, 5'd15, 5'd0};
        scored_row({5'd17, 5'd4, 5'd15, 5'd0, 5'd15}, 10'b00_01_10_01_01, "paper");

        // ABBEY vs BBBBB and YEBBA
        bus.targetFlat = {5'd24, 5'd4, 5'd1, 5'd1, 5'd0};
        scored_row({5'd1, 5'd1, 5'd1, 5'd1, 5'd1}, 10'b00_00_10_10_00, "bbbbb");
        scored_row({5'd0, 5'd1, 5'd1, 5'd4, 5'd24}, 10'b01_01_10_01_01, "yebba");
        scored_row({5'd24, 5'd4, 5'd1, 5'd1, 5'd0}, 10'b10_10_10_10_10, "win");
        ignored_submit(rand_word(), "after_win");

        // Six random misses
        reset_dut("reset2");
        tgt = rand_word();
        bus.targetFlat = tgt;
        for (int r = 0; r < 6; r++) begin
            g = rand_guess(tgt);
            while (g == tgt) g = rand_guess(tgt);
            scored_row(g, wordle(g, tgt), $sformatf("miss%0d", r));
        end
        chk("six_final", {bus.rowIndex, bus.doneGame, bus.won}, {3'd6, 1'b1, 1'b0});
        ignored_submit(rand_word(), "after_six");

        // Reject on blank column 2, then abort a valid row by reset
        reset_dut("reset3");
        tgt = rand_word();
        bus.targetFlat = tgt;
        g = rand_word();
        write_col(0, g[0 +: 5]);
        write_col(1, g[5 +: 5]);
        write_col(3, g[15 +: 5]);
        bus.we = 1'b1;
        bus.columnIn = 3'd4;
        bus.value = {2'b11, g[20 +: 5]};
        bus.submitted = 1'b1;
        tick();
        bus.we = 1'b0;
        bus.submitted = 1'b0;
        expf = flat_of(g, 10'd0);
        expf[14 +: 7] = 7'd26;
        chk("rej_pulse", {bus.rejected, bus.busy}, 2'b10);
        chk("rej_row", bus.rowValuesFlat, expf);
        tick();
        chk("rej_one", {bus.rejected, bus.busy}, 2'b00);
        write_col(2, g[10 +: 5]);
        bus.submitted = 1'b1;
        bus.columnIn = 3'd4;
        bus.value = {2'b00, g[20 +: 5]};
        tick();
        bus.submitted = 1'b0;
        chk("abort_busy", bus.busy, 1);
        tick();
        tick();
        tick();
        clr_n = 1'b0;
        #1 check_reset("abort");
        tick();
        clr_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus.scoreValid || bus.busy) cnt++;
            tick();
        end
        chk("abort_nosv", 35'(cnt), 0);
        check_reset("abort_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/row_scorer.md
# row_scorer

Guess-row buffer and Wordle scorer on the receiving side of the letter-selection stage. It captures the cursor's `{color, letter}` writes per column and returns the live row as `rowValuesFlat`. On `submitted` it snapshots the row and scores it against the 5-letter target using Wordle duplicate-letter rules. It then publishes the colored row, the row count, and the `doneGame`/`won` status to the display and selection logic.

## Interface
- No parameters; the word is 5 letters (0..25 = A..Z, 26 = blank), the game is 6 rows, and colors are 0 grey, 1 yellow, 2 green, 3 red.
- `clk`  in  1  single clock for the block.
- `clr_n`  in  1  asynchronous, active-low reset.
- `we`  in  1  write enable for the live row buffer.
- `columnIn`  in  3  cursor column, 0..4.
- `value`  in  7  cursor value; bits [4:0] are the letter, color bits [6:5] are ignored.
- `submitted`  in  1  single-cycle row-submit pulse.
- `targetFlat`  in  25  target word; letter k is at [5k+4:5k]; must be held stable.
- `rowValuesFlat`  out  35  live row; slot k is at [7k+6:7k], with color 00.
- `scoredFlat`  out  35  last scored row, as `{color, letter}` per slot.
- `scoreValid`  out  1  one-cycle pulse when `scoredFlat` updates.
- `rejected`  out  1  one-cycle pulse when a submit contains a blank.
- `busy`  out  1  high while scoring.
- `rowIndex`  out  3  number of rows scored, 0..6.
- `doneGame`  out  1  sticky; set on a win or after 6 rows.
- `won`  out  1  sticky; set on an all-green row.

## Operation
- FSM states: IDLE, GREEN, YEL0..YEL4, DONE.
- Reset values:
  - every `rowValuesFlat` slot and every `scoredFlat` slot = 7'd26;
  - all other outputs = 0;
  - state = IDLE.
- IDLE write: when `we` is high and `columnIn` ≤ 4, slot[`columnIn`] <= {2'b00, `value`[4:0]}. `columnIn` 5..7 is ignored.
- IDLE submit: on `submitted` with `doneGame` = 0, form the snapshot S = buffer with slot[`columnIn`] replaced by `value`[4:0].
  - If any letter of S is 26: pulse `rejected`. The buffer is updated by the write only; the state stays IDLE.
  - Otherwise: latch S, clear all buffer slots to 26, set `busy`, and go to GREEN.
- GREEN: for each k, if S[k] == target[k], color[k] = 2 and `used`[k] = 1. Every other color = 0 and every other `used` bit = 0.
- YELi (i = 0..4, ascending): if color[i] ≠ 2, find the lowest j with `used`[j] = 0 and target[j] == S[i]. If found, color[i] = 1 and `used`[j] = 1. Each target letter is consumed at most once.
- DONE:
  - `scoredFlat` <= {color, S}; pulse `scoreValid`;
  - `rowIndex` += 1; clear `busy`;
  - if all five colors are 2, set `won` and `doneGame`; else if the new `rowIndex` == 6, set `doneGame`;
  - return to IDLE.
- While `busy`: `we` and `submitted` are ignored.
- While `doneGame`: submits are ignored (no `rejected` pulse, no buffer clear). Writes are still accepted.
- Red (3) is never produced by this block.

## Timing
- `submitted` sampled at edge t → `busy` high from t; GREEN t+1; YEL0..4 t+2..t+6; DONE t+7.
- `scoreValid`, the `scoredFlat` update, `rowIndex`, `won` and `doneGame` are all visible after edge t+7 (latency 7 cycles). `busy` falls at the same edge.
- `rejected` is visible after edge t, for exactly one cycle.
- Buffer clear on an accepted submit is visible after edge t, so the next cycle's `rowValuesFlat` reads all blank.
- A write and an accepted submit in the same cycle: the snapshot includes the write, and the buffer clear takes priority over the write.
- Earliest next accepted submit: edge t+8.
- `clr_n` low at any time, including mid-scoring: immediately return all outputs to their reset values and the state to IDLE, and drop the in-flight score.
- `doneGame` and `won` clear only on reset.

## Test plan
- **Reset:** pulse `clr_n` low → `rowValuesFlat` = `scoredFlat` = five slots of 26; `rowIndex`/`doneGame`/`won`/`busy` = 0.
- **Basic scoring:** target APPLE (0,15,15,11,4); write P,A,P,E,R to columns 0..4; submit at column 4 → `scoreValid` at t+7; colors 1,1,2,1,0; `rowIndex` = 1; `rowValuesFlat` all 26 from t+1.
- **Duplicates:** target ABBEY (0,1,1,4,24), guess BBBBB → colors 0,2,2,0,0. Guess YEBBA → colors 1,1,2,1,1.
- **Win:** guess equal to the target → all colors 2, `won` = 1, `doneGame` = 1. A later submit gives no `scoreValid`, no `rejected`, and no buffer clear.
- **Six misses:** submit six non-matching full rows → `rowIndex` = 6, `doneGame` = 1, `won` = 0.
- **Reject and abort:** submit with column 2 blank → `rejected` one cycle, `busy` stays 0. Then a valid submit, `clr_n` low at t+3 → no `scoreValid`, all outputs at reset values.
